// File: rtl/regfile_exec_sequencer.sv
// rtl/regfile_exec_sequencer.sv - multi-cycle R-type sequencer driving register bank and ALU
//
// Accepts one MIPS R-type instruction at a time over instr_valid/instr_ready,
// presents rs/rt/rd and the ALU control code, waits ALU_LATENCY cycles, latches
// the ALU result and issues a single-cycle register write strobe.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   instr, instr_valid   instruction word and its valid
//   instr_ready          high only in IDLE
//   rs_addr, rt_addr     register bank read addresses
//   rd_addr              register bank write address
//   alu_ctrl             ALU operation code
//   alu_result           ALU output, sampled on the last EXEC cycle
//   wb_data              latched ALU result for the bank write port
//   reg_write            write enable pulse (suppressed for register 0)
//   retire, illegal      completion pulse; illegal flags unsupported instructions
//   busy                 high outside IDLE
module regfile_exec_sequencer #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic [31:0] wb_data,
    output logic        reg_write,
    output logic        retire,
    output logic        illegal,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        FAULT  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        legal_q, legal_d;

    logic        dec_legal;
    logic [3:0]  dec_ctrl;

    // shamt plays no part in the supported operations.
    logic        unused_shamt;
    assign unused_shamt = ^instr[10:6];

    // Legality and ALU code are resolved at the handshake so alu_ctrl is
    // already valid in the DECODE cycle alongside the register addresses.
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = 4'b0000;
        if (instr[31:26] == 6'd0) begin
            case (instr[5:0])
                6'h20: begin dec_legal = 1'b1; dec_ctrl = 4'b0010; end
                6'h22: begin dec_legal = 1'b1; dec_ctrl = 4'b0110; end
                6'h24: begin dec_legal = 1'b1; dec_ctrl = 4'b0000; end
                6'h25: begin dec_legal = 1'b1; dec_ctrl = 4'b0001; end
                6'h2A: begin dec_legal = 1'b1; dec_ctrl = 4'b0111; end
                default: begin dec_legal = 1'b0; dec_ctrl = 4'b0000; end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        alu_ctrl_d = alu_ctrl_q;
        wb_data_d  = wb_data_q;
        legal_d    = legal_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d = DECODE;
                    rs_d    = instr[25:21];
                    rt_d    = instr[20:16];
                    rd_d    = instr[15:11];
                    legal_d = dec_legal;
                    // An illegal instruction leaves the previous ALU code in place.
                    if (dec_legal) begin
                        alu_ctrl_d = dec_ctrl;
                    end
                end
            end
            DECODE: begin
                if (legal_q) begin
                    cnt_d   = 4'(ALU_LATENCY);
                    state_d = EXEC;
                end else begin
                    state_d = FAULT;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd1) begin
                    wb_data_d = alu_result;
                    cnt_d     = 4'd0;
                    state_d   = WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB:      state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            alu_ctrl_q <= 4'b0000;
            wb_data_q  <= 32'd0;
            legal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            alu_ctrl_q <= alu_ctrl_d;
            wb_data_q  <= wb_data_d;
            legal_q    <= legal_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rs_addr     = rs_q;
    assign rt_addr     = rt_q;
    assign rd_addr     = rd_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign wb_data     = wb_data_q;
    // Register 0 is hardwired to zero, so it is never written.
    assign reg_write   = (state_q == WB) && (rd_q != 5'd0);
    assign retire      = (state_q == WB) || (state_q == FAULT);
    assign illegal     = (state_q == FAULT);

endmodule

// File: tb/tb_regfile_exec_sequencer.sv
// tb/tb_regfile_exec_sequencer.sv - directed self-checking bench for regfile_exec_sequencer
module tb_regfile_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1;
    logic [31:0] instr;
    logic [31:0] alu_result;

    logic [1:0]  ready, busy, reg_write, retire, illegal;
    logic [4:0]  rs [2];
    logic [4:0]  rt [2];
    logic [4:0]  rd [2];
    logic [3:0]  ctrl [2];
    logic [31:0] wb [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_exec_sequencer #(.ALU_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(v0),
        .instr_ready(ready[0]), .rs_addr(rs[0]), .rt_addr(rt[0]), .rd_addr(rd[0]),
        .alu_ctrl(ctrl[0]), .alu_result(alu_result), .wb_data(wb[0]),
        .reg_write(reg_write[0]), .retire(retire[0]), .illegal(illegal[0]), .busy(busy[0])
    );

    regfile_exec_sequencer #(.ALU_LATENCY(4)) dut_l4 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(v1),
        .instr_ready(ready[1]), .rs_addr(rs[1]), .rt_addr(rt[1]), .rd_addr(rd[1]),
        .alu_ctrl(ctrl[1]), .alu_result(alu_result), .wb_data(wb[1]),
        .reg_write(reg_write[1]), .retire(retire[1]), .illegal(illegal[1]), .busy(busy[1])
    );

    task automatic test_reset();
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; instr = 32'd0; alu_result = 32'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++; if (ready[s] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: got %b want 1", s, ready[s]); end
            checks++; if (busy[s] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", s, busy[s]); end
            checks++; if ({rs[s], rt[s], rd[s]} !== 15'd0) begin errors++; $display("FAIL reset_addr dut%0d: got %h want 0", s, {rs[s], rt[s], rd[s]}); end
            checks++; if (ctrl[s] !== 4'b0000) begin errors++; $display("FAIL reset_ctrl dut%0d: got %b want 0000", s, ctrl[s]); end
            checks++; if (wb[s] !== 32'd0) begin errors++; $display("FAIL reset_wb dut%0d: got %h want 0", s, wb[s]); end
            checks++; if ({reg_write[s], retire[s], illegal[s]} !== 3'b000) begin errors++; $display("FAIL reset_pulses dut%0d: got %b want 000", s, {reg_write[s], retire[s], illegal[s]}); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ready[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b want 1/0", ready[0], busy[0]); end
    endtask

    task automatic test_add();
        instr = 32'h00221820; alu_result = 32'd77; v0 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) v0 = 1'b0;
            if (c == 2) alu_result = 32'd3;
            checks++; if ({rs[0], rt[0], rd[0]} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL add_addr c%0d: got %0d/%0d/%0d want 1/2/3", c, rs[0], rt[0], rd[0]); end
            checks++; if (ctrl[0] !== 4'b0010) begin errors++; $display("FAIL add_ctrl c%0d: got %b want 0010", c, ctrl[0]); end
            checks++; if (reg_write[0] !== (c == 3)) begin errors++; $display("FAIL add_reg_write c%0d: got %b want %b", c, reg_write[0], c == 3); end
            checks++; if (retire[0] !== (c == 3) || illegal[0] !== 1'b0) begin errors++; $display("FAIL add_retire c%0d: got %b/%b want %b/0", c, retire[0], illegal[0], c == 3); end
            checks++; if (ready[0] !== (c == 4) || busy[0] !== (c <= 3)) begin errors++; $display("FAIL add_ready_busy c%0d: got %b/%b", c, ready[0], busy[0]); end
            if (c == 3) begin
                checks++; if (wb[0] !== 32'd3) begin errors++; $display("FAIL add_wb_data: got %h want 3", wb[0]); end
            end
        end
    endtask

    task automatic test_latency();
        instr = 32'h00812822; alu_result = 32'd99; v1 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) v1 = 1'b0;
            if (c == 5) alu_result = 32'd3;
            checks++; if ({rs[1], rt[1], rd[1]} !== {5'd4, 5'd1, 5'd5}) begin errors++; $display("FAIL lat_addr c%0d: got %0d/%0d/%0d want 4/1/5", c, rs[1], rt[1], rd[1]); end
            checks++; if (ctrl[1] !== 4'b0110) begin errors++; $display("FAIL lat_ctrl c%0d: got %b want 0110", c, ctrl[1]); end
            checks++; if (reg_write[1] !== (c == 6) || retire[1] !== (c == 6)) begin errors++; $display("FAIL lat_wb_pulse c%0d: got %b/%b want %b", c, reg_write[1], retire[1], c == 6); end
            checks++; if (busy[1] !== (c <= 6) || ready[1] !== (c == 7)) begin errors++; $display("FAIL lat_busy c%0d: got busy=%b ready=%b", c, busy[1], ready[1]); end
            if (c == 6) begin
                checks++; if (wb[1] !== 32'd3) begin errors++; $display("FAIL lat_wb_data: got %h want 3", wb[1]); end
            end
        end
    endtask

    task automatic test_write_zero();
        instr = 32'h00220020; alu_result = 32'd5; v0 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) v0 = 1'b0;
            checks++; if (rd[0] !== 5'd0) begin errors++; $display("FAIL zero_rd c%0d: got %0d want 0", c, rd[0]); end
            checks++; if (reg_write[0] !== 1'b0) begin errors++; $display("FAIL zero_reg_write c%0d: got %b want 0", c, reg_write[0]); end
            checks++; if (retire[0] !== (c == 3)) begin errors++; $display("FAIL zero_retire c%0d: got %b want %b", c, retire[0], c == 3); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = 32'h8C220004;
        bad[1] = 32'h00221821;
        for (int i = 0; i < 2; i++) begin
            instr = bad[i]; v0 = 1'b1;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (c == 1) v0 = 1'b0;
                checks++; if (retire[0] !== (c == 2) || illegal[0] !== (c == 2)) begin errors++; $display("FAIL ill%0d_pulse c%0d: got %b/%b want %b", i, c, retire[0], illegal[0], c == 2); end
                checks++; if (reg_write[0] !== 1'b0) begin errors++; $display("FAIL ill%0d_reg_write c%0d: got %b want 0", i, c, reg_write[0]); end
                checks++; if (ctrl[0] !== 4'b0010) begin errors++; $display("FAIL ill%0d_ctrl_hold c%0d: got %b want 0010", i, c, ctrl[0]); end
                checks++; if (ready[0] !== (c == 3)) begin errors++; $display("FAIL ill%0d_ready c%0d: got %b want %b", i, c, ready[0], c == 3); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int writes = 0;
        instr = 32'h00221824; alu_result = 32'd7; v0 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) instr = 32'h0022202A;
            if (c == 4) alu_result = 32'd1;
            if (c == 5) v0 = 1'b0;
            if (reg_write[0] === 1'b1) writes++;
            if (c == 1) begin
                checks++; if (ctrl[0] !== 4'b0000 || rd[0] !== 5'd3) begin errors++; $display("FAIL b2b_first_decode: got ctrl=%b rd=%0d want 0000/3", ctrl[0], rd[0]); end
            end
            if (c == 3) begin
                checks++; if (wb[0] !== 32'd7) begin errors++; $display("FAIL b2b_first_wb: got %h want 7", wb[0]); end
            end
            if (c == 4) begin
                checks++; if (ready[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_gap_idle: got ready=%b busy=%b want 1/0", ready[0], busy[0]); end
            end
            if (c == 5) begin
                checks++; if (ctrl[0] !== 4'b0111 || rd[0] !== 5'd4 || busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_decode: got ctrl=%b rd=%0d busy=%b want 0111/4/1", ctrl[0], rd[0], busy[0]); end
            end
            if (c == 7) begin
                checks++; if (wb[0] !== 32'd1 || reg_write[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_wb: got wb=%h we=%b want 1/1", wb[0], reg_write[0]); end
            end
        end
        checks++; if (writes != 2) begin errors++; $display("FAIL b2b_write_count: got %0d want 2", writes); end
    endtask

    task automatic test_reset_mid_exec();
        instr = 32'h00221820; alu_result = 32'd5; v1 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) v1 = 1'b0;
        end
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy[1]); end
        rst_n = 1'b0;
        #1;
        checks++; if (ready[1] !== 1'b1 || busy[1] !== 1'b0) begin errors++; $display("FAIL mid_async_state: got ready=%b busy=%b want 1/0", ready[1], busy[1]); end
        checks++; if ({rs[1], rt[1], rd[1]} !== 15'd0 || ctrl[1] !== 4'b0000) begin errors++; $display("FAIL mid_async_regs: got addr=%h ctrl=%b want 0/0000", {rs[1], rt[1], rd[1]}, ctrl[1]); end
        checks++; if (wb[1] !== 32'd0) begin errors++; $display("FAIL mid_async_wb: got %h want 0", wb[1]); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (reg_write[1] !== 1'b0 || retire[1] !== 1'b0 || busy[1] !== 1'b0) begin errors++; $display("FAIL mid_after c%0d: got we=%b retire=%b busy=%b want 0/0/0", c, reg_write[1], retire[1], busy[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_latency();
        test_write_zero();
        test_illegal();
        test_back_to_back();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
